// File: rtl/riscv_hwloop_unit.sv
// Hardware-loop register file: per-set start/end/count, end-of-loop match,
// jump target selection and retire-time counter decrement.
module riscv_hwloop_unit #(
   parameter int N_REGS     = 2,
   parameter int ADDR_W     = 32,
   parameter int CNT_W      = 32,
   parameter int N_REG_BITS = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear_i,
   input  logic [2:0]               we_i,
   input  logic [N_REG_BITS-1:0]    regid_i,
   input  logic [ADDR_W-1:0]        start_data_i,
   input  logic [ADDR_W-1:0]        end_data_i,
   input  logic [CNT_W-1:0]         cnt_data_i,
   input  logic [ADDR_W-1:0]        pc_i,
   input  logic                     valid_i,
   output logic                     jump_o,
   output logic [ADDR_W-1:0]        jump_target_o,
   output logic [N_REGS-1:0]        active_o,
   output logic [N_REGS-1:0]        done_o,
   output logic [N_REGS*ADDR_W-1:0] start_addr_o,
   output logic [N_REGS*ADDR_W-1:0] end_addr_o,
   output logic [N_REGS*CNT_W-1:0]  counter_o
);

   logic [N_REGS-1:0][ADDR_W-1:0] start_q;
   logic [N_REGS-1:0][ADDR_W-1:0] end_q;
   logic [N_REGS-1:0][CNT_W-1:0]  counter_q;
   logic [N_REGS-1:0]             done_q;

   logic [N_REGS-1:0] wsel;
   logic [N_REGS-1:0] match;
   logic [N_REGS-1:0] sel_oh;

   always_comb begin
      wsel          = '0;
      match         = '0;
      sel_oh        = '0;
      jump_o        = 1'b0;
      jump_target_o = '0;
      for (int k = 0; k < N_REGS; k++) begin
         wsel[k]  = (int'(regid_i) == k);
         match[k] = (counter_q[k] != '0) && (pc_i == end_q[k]);
      end
      // scan outermost to innermost so the innermost match wins
      for (int k = N_REGS - 1; k >= 0; k--) begin
         if (match[k]) begin
            sel_oh        = '0;
            sel_oh[k]     = 1'b1;
            jump_o        = (counter_q[k] > CNT_W'(1));
            jump_target_o = start_q[k];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_q   <= '0;
         end_q     <= '0;
         counter_q <= '0;
         done_q    <= '0;
      end else begin
         done_q <= '0;
         for (int k = 0; k < N_REGS; k++) begin
            if (wsel[k] && we_i[0]) start_q[k] <= start_data_i;
            if (wsel[k] && we_i[1]) end_q[k] <= end_data_i;
            if (clear_i) begin
               counter_q[k] <= '0;
            end else if (wsel[k] && we_i[2]) begin
               counter_q[k] <= cnt_data_i;
            end else if (sel_oh[k] && valid_i) begin
               counter_q[k] <= counter_q[k] - CNT_W'(1);
               done_q[k]    <= (counter_q[k] == CNT_W'(1));
            end
         end
      end
   end

   always_comb begin
      active_o = '0;
      for (int k = 0; k < N_REGS; k++) active_o[k] = (counter_q[k] != '0);
   end

   assign done_o       = done_q;
   assign start_addr_o = start_q;
   assign end_addr_o   = end_q;
   assign counter_o    = counter_q;

endmodule
